// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array feeder.
// Holds the issue FSM encoding and the counter-width helper used by the feeder and its banks.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } feed_state_t;

  localparam int DEFAULT_DATAWIDTH = 16;
  localparam int DEFAULT_N_SIZE    = 3;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_bank.sv
// One N x N operand bank: element-wise write port, combinational read of
// column t of A and row t of B for the array's per-cycle input format.
module matrix_bank
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int N_SIZE    = DEFAULT_N_SIZE,
  localparam int IDX_W    = idx_width(N_SIZE)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     row,
  input  logic [IDX_W-1:0]     col,
  input  logic [DATAWIDTH-1:0] a_din,
  input  logic [DATAWIDTH-1:0] b_din,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DATAWIDTH-1:0] a_col [N_SIZE],
  output logic [DATAWIDTH-1:0] b_row [N_SIZE]
);

  logic [DATAWIDTH-1:0] a_mem_q [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] a_mem_d [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b_mem_q [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b_mem_d [N_SIZE][N_SIZE];

  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (we) begin
      a_mem_d[row][col] = a_din;
      b_mem_d[row][col] = b_din;
    end
  end

  // Contents are not reset: a bank is only read after a full reload.
  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  for (genvar gi = 0; gi < N_SIZE; gi++) begin : g_read
    assign a_col[gi] = a_mem_q[gi][rd_idx];
    assign b_row[gi] = b_mem_q[rd_idx][gi];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Ping-pong operand buffer in front of systolic_array: loads A/B element-serially,
// then replays each pair as one gap-free N-cycle burst and waits for the result window.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int N_SIZE    = DEFAULT_N_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DATAWIDTH-1:0] ld_a_data,
  input  logic [DATAWIDTH-1:0] ld_b_data,
  output logic                 mat_valid,
  output logic [DATAWIDTH-1:0] mat_a_out [N_SIZE],
  output logic [DATAWIDTH-1:0] mat_b_out [N_SIZE],
  input  logic                 arr_valid_out,
  output logic                 busy
);

  localparam int NN    = N_SIZE * N_SIZE;
  localparam int LD_W  = idx_width(NN);
  localparam int IDX_W = idx_width(N_SIZE);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(NN - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(N_SIZE - 1);
  localparam logic [LD_W-1:0]  LD_N     = LD_W'(N_SIZE);

  feed_state_t     state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic            done_seen_q, done_seen_d;

  logic             ld_fire;
  logic             ld_last;
  logic             stream_end;
  logic [IDX_W-1:0] ld_row;
  logic [IDX_W-1:0] ld_col;
  logic [1:0]       bank_we;
  logic [DATAWIDTH-1:0] bank_a_col [2][N_SIZE];
  logic [DATAWIDTH-1:0] bank_b_row [2][N_SIZE];

  // Load side: row-major beats into the bank selected by wr_bank.
  assign ld_ready = ~full_q[wr_bank_q];
  assign ld_fire  = ld_valid & ld_ready;
  assign ld_last  = ld_fire && (ld_cnt_q == LD_LAST);
  assign ld_row   = IDX_W'(ld_cnt_q / LD_N);
  assign ld_col   = IDX_W'(ld_cnt_q % LD_N);

  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    wr_bank_d = wr_bank_q;
    if (ld_fire) begin
      if (ld_last) begin
        ld_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        ld_cnt_d = ld_cnt_q + 1'b1;
      end
    end
  end

  // Issue FSM: the burst must not stall once started, so t advances unconditionally.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rd_bank_d   = rd_bank_q;
    done_seen_d = done_seen_q;
    stream_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = STREAM;
          col_d   = '0;
        end
      end
      STREAM: begin
        col_d = col_q + 1'b1;
        if (col_q == COL_LAST) begin
          stream_end  = 1'b1;
          col_d       = '0;
          rd_bank_d   = ~rd_bank_q;
          state_d     = WAIT_DONE;
          done_seen_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (arr_valid_out) begin
          done_seen_d = 1'b1;
        end else if (done_seen_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set and clear can land on the same edge, but always on different banks.
  always_comb begin
    full_d = full_q;
    if (stream_end) full_d[rd_bank_q] = 1'b0;
    if (ld_last)    full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      ld_cnt_q    <= '0;
      col_q       <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      ld_cnt_q    <= ld_cnt_d;
      col_q       <= col_d;
      done_seen_q <= done_seen_d;
    end
  end

  bank_collision_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(ld_last && stream_end && (wr_bank_q == rd_bank_q)));

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_we[gi] = ld_fire && (wr_bank_q == 1'(gi));
    matrix_bank #(
      .DATAWIDTH (DATAWIDTH),
      .N_SIZE    (N_SIZE)
    ) u_bank (
      .clk    (clk),
      .we     (bank_we[gi]),
      .row    (ld_row),
      .col    (ld_col),
      .a_din  (ld_a_data),
      .b_din  (ld_b_data),
      .rd_idx (col_q),
      .a_col  (bank_a_col[gi]),
      .b_row  (bank_b_row[gi])
    );
  end

  assign mat_valid = (state_q == STREAM);
  assign busy      = (state_q != IDLE);

  for (genvar gi = 0; gi < N_SIZE; gi++) begin : g_out
    assign mat_a_out[gi] = mat_valid ? bank_a_col[rd_bank_q][gi] : '0;
    assign mat_b_out[gi] = mat_valid ? bank_b_row[rd_bank_q][gi] : '0;
  end

endmodule
